sdram_wb_bridge: RTL

//   Wishbone slave front-end sitting between the bus arbiter and sdram_controller.
//   - Converts the arbiter's Wishbone cycle into the controller's in_valid/busy/out_valid handshake.
//   - Posts writes into a small write FIFO and acks them early.
//   - Drains pending writes before any read, so reads never return stale data.
//   - Bounds read latency with a timeout.

---
 rtl/sdram_wb_bridge_pkg.sv | 23 ++
 rtl/sdram_wb_bridge_if.sv | 41 ++++
 rtl/sdram_wb_bridge_wfifo.sv | 52 +++++
 rtl/sdram_wb_bridge.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sdram_wb_bridge_pkg.sv
// Shared types for the Wishbone-to-SDRAM-controller bridge: read FSM states and the
// posted-write FIFO entry layout.
package sdram_wb_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StRdIssue,
    StRdWait,
    StRdAck
  } bridge_state_e;

  // addr is sized for the widest controller; only the low ADDR_W bits are ever non-zero
  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } wfifo_entry_t;

  localparam int unsigned WfifoEntryW   = $bits(wfifo_entry_t);
  localparam logic [31:0] DefTimeoutDat = 32'hDEADBEEF;

endpackage

// File: rtl/sdram_wb_bridge_if.sv
// Wishbone slave side plus sdram_controller command side of the bridge, with status outputs.
interface sdram_wb_bridge_if #(
  parameter int unsigned ADDR_W  = 23,
  parameter int unsigned LEVEL_W = 3
);
  logic               wbs_stb_i;
  logic               wbs_cyc_i;
  logic               wbs_we_i;
  logic [3:0]         wbs_sel_i;
  logic [31:0]        wbs_dat_i;
  logic [31:0]        wbs_adr_i;
  logic               wbs_ack_o;
  logic [31:0]        wbs_dat_o;
  logic               ctrl_in_valid;
  logic               ctrl_rw;
  logic [ADDR_W-1:0]  ctrl_addr;
  logic [31:0]        ctrl_data;
  logic [3:0]         ctrl_sel;
  logic               ctrl_busy;
  logic               ctrl_out_valid;
  logic [31:0]        ctrl_rdata;
  logic [LEVEL_W-1:0] wfifo_level;
  logic               rd_timeout_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o,
    output ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_data, ctrl_sel,
    input  ctrl_busy, ctrl_out_valid, ctrl_rdata,
    output wfifo_level, rd_timeout_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o,
    input  ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_data, ctrl_sel,
    output ctrl_busy, ctrl_out_valid, ctrl_rdata,
    input  wfifo_level, rd_timeout_o
  );

endinterface

// File: rtl/sdram_wb_bridge_wfifo.sv
// Posted-write FIFO: power-of-two depth, registered occupancy, push ignored when full,
// pop ignored when empty. Head entry is presented combinationally on rdata.
module sdram_wb_bridge_wfifo #(
  parameter int unsigned Width = 68,
  parameter int unsigned Depth = 4,
  localparam int unsigned AW   = $clog2(Depth),
  localparam int unsigned LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == LW'(Depth));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sdram_wb_bridge.sv
// Wishbone slave front-end for sdram_controller: posted writes through a small FIFO, reads
// issued only after the FIFO drains, and a bounded read wait that returns a marker on timeout.
module sdram_wb_bridge
  import sdram_wb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 23,
  parameter int unsigned WFIFO_DEPTH = 4,
  parameter int unsigned RD_TIMEOUT  = 64,
  parameter logic [31:0] TIMEOUT_DAT = DefTimeoutDat
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  sdram_wb_bridge_if.slave bus
);

  localparam int unsigned LW = $clog2(WFIFO_DEPTH) + 1;
  localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

  bridge_state_e     state_q;
  logic              ack_q;
  logic              timeout_q;
  logic [31:0]       dat_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [TW-1:0]     timer_q;

  logic                   req, wr_accept, rd_req, drain, rd_issue;
  logic                   full, empty;
  logic [LW-1:0]          level;
  logic [ADDR_W-1:0]      req_addr;
  logic [WfifoEntryW-1:0] head_raw;
  wfifo_entry_t           push_entry, head;
  logic                   unused_bits;

  // Wishbone address is a byte address; the controller takes 32-bit word addresses.
  assign req_addr    = bus.wbs_adr_i[ADDR_W+1:2];
  assign unused_bits = ^{bus.wbs_adr_i[31:ADDR_W+2], bus.wbs_adr_i[1:0], head.addr[31:ADDR_W]};

  // Gating on ack_q stops the still-asserted strobe from being accepted twice.
  assign req       = bus.wbs_stb_i & bus.wbs_cyc_i & ~ack_q;
  assign wr_accept = req & bus.wbs_we_i & ~full;
  assign rd_req    = req & ~bus.wbs_we_i;
  assign drain     = ~empty & ~bus.ctrl_busy & ((state_q == StIdle) | (state_q == StDrain));
  assign rd_issue  = (state_q == StRdIssue) & ~bus.ctrl_busy;

  always_comb begin
    push_entry                   = '0;
    push_entry.sel               = bus.wbs_sel_i;
    push_entry.addr[ADDR_W-1:0]  = req_addr;
    push_entry.data              = bus.wbs_dat_i;
  end

  sdram_wb_bridge_wfifo #(
    .Width (WfifoEntryW),
    .Depth (WFIFO_DEPTH)
  ) u_wfifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (wr_accept),
    .wdata (push_entry),
    .pop   (drain),
    .rdata (head_raw),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign head = wfifo_entry_t'(head_raw);

  always_comb begin
    bus.ctrl_in_valid = drain | rd_issue;
    bus.ctrl_rw       = drain;
    bus.ctrl_addr     = '0;
    bus.ctrl_data     = '0;
    bus.ctrl_sel      = '0;
    if (drain) begin
      bus.ctrl_addr = head.addr[ADDR_W-1:0];
      bus.ctrl_data = head.data;
      bus.ctrl_sel  = head.sel;
    end else if (rd_issue) begin
      bus.ctrl_addr = rd_addr_q;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      timeout_q <= 1'b0;
      timer_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      ack_q <= wr_accept;
      unique case (state_q)
        StIdle: begin
          if (rd_req) begin
            rd_addr_q <= req_addr;
            state_q   <= empty ? StRdIssue : StDrain;
          end
        end
        StDrain: begin
          if (empty) state_q <= StRdIssue;
        end
        StRdIssue: begin
          if (!bus.ctrl_busy) begin
            timer_q <= '0;
            state_q <= StRdWait;
          end
        end
        StRdWait: begin
          // Real data wins over a timeout landing in the same cycle.
          if (bus.ctrl_out_valid) begin
            dat_q   <= bus.ctrl_rdata;
            ack_q   <= 1'b1;
            state_q <= StRdAck;
          end else if (timer_q == TW'(RD_TIMEOUT - 1)) begin
            dat_q     <= TIMEOUT_DAT;
            timeout_q <= 1'b1;
            ack_q     <= 1'b1;
            state_q   <= StRdAck;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StRdAck: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.wbs_ack_o    = ack_q;
  assign bus.wbs_dat_o    = dat_q;
  assign bus.wfifo_level  = level;
  assign bus.rd_timeout_o = timeout_q;

endmodule
